prga_prog_ctrl: RTL

- Wishbone-slave bitstream loader that sequences the PRGA fabric programming interface (prog_rst, prog_we, prog_din, prog_done) from the Caravel management core.
- Firmware writes 32-bit bitstream words into a small FIFO. The block serialises each word MSB-first onto prog_din, one bit per clock, with prog_we high.
- Sits in user_project_wrapper between the Wishbone port and the fabric top, replacing GPIO-driven programming.

---
 rtl/prga_prog_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/prga_prog_ctrl.sv
// Wishbone-slave bitstream loader for the PRGA fabric: buffers 32-bit words in a
// small FIFO and shifts them MSB-first onto prog_din while sequencing prog_rst/prog_done.
module prga_prog_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          RST_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        prog_rst,
    output logic        prog_we,
    output logic        prog_din,
    output logic        prog_done,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [31:0]    bitcnt_q, bitcnt_d;
    logic [31:0]    sr_q, sr_d;
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]    fifo_mem_q [FIFO_DEPTH];
    logic [31:0]    fifo_mem_d [FIFO_DEPTH];
    logic           overflow_q, overflow_d;
    logic           finish_q, finish_d;
    logic           ack_q, ack_d;
    logic [31:0]    dat_q, dat_d;
    logic           prog_rst_q, prog_rst_d;
    logic           prog_we_q, prog_we_d;
    logic           prog_din_q, prog_din_d;
    logic           prog_done_q, prog_done_d;
    logic           irq_q, irq_d;

    logic       req, wr, rd;
    logic [1:0] off;
    logic       start_w, finish_w, abort_w, data_w;
    logic       fifo_empty, fifo_full, accept_state;
    logic       pop, shift_en;
    logic       unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

    // Gating on ack_q keeps ack from ever being asserted on two consecutive cycles.
    assign req = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
    assign wr  = req & wbs_we_i;
    assign rd  = req & ~wbs_we_i;
    assign off = wbs_adr_i[3:2];

    assign start_w  = wr && (off == 2'd0) && wbs_dat_i[0];
    assign finish_w = wr && (off == 2'd0) && wbs_dat_i[1];
    assign abort_w  = wr && (off == 2'd0) && wbs_dat_i[2];
    assign data_w   = wr && (off == 2'd2);

    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                          (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign accept_state = (state_q == S_RST) || (state_q == S_LOAD) || (state_q == S_SHIFT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        sr_d       = sr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_mem_d = fifo_mem_q;
        overflow_d = overflow_q;
        finish_d   = finish_q;
        pop        = 1'b0;
        shift_en   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_w && !abort_w) begin
                    state_d    = S_RST;
                    cnt_d      = 32'(RST_CYCLES);
                    bitcnt_d   = '0;
                    overflow_d = 1'b0;
                    finish_d   = 1'b0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                end
            end
            S_RST: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else if (finish_q) begin
                    state_d = S_DONE;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                sr_d     = {sr_q[30:0], 1'b0};
                bitcnt_d = bitcnt_q + 32'd1;
                cnt_d    = cnt_q + 32'd1;
                if (cnt_q == 32'd31) begin
                    // Chain straight into the next word so prog_we never drops between words.
                    if (!fifo_empty) begin
                        pop   = 1'b1;
                        cnt_d = '0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            sr_d     = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
        if (data_w) begin
            if (accept_state && (!fifo_full || pop)) begin
                fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = wbs_dat_i;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (finish_w && accept_state) finish_d = 1'b1;

        if (abort_w) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            shift_en = 1'b0;
            bitcnt_d = bitcnt_q;
            cnt_d    = cnt_q;
        end
    end

    always_comb begin
        prog_rst_d  = (state_d == S_IDLE) || (state_d == S_RST);
        prog_we_d   = shift_en;
        prog_din_d  = shift_en & sr_q[31];
        prog_done_d = (state_d == S_DONE);
        irq_d       = (state_d == S_DONE) && (state_q != S_DONE);
        ack_d       = req;
        dat_d       = '0;
        if (rd) begin
            case (off)
                2'd1:    dat_d = {25'd0, finish_q, overflow_q, fifo_empty, fifo_full, state_q};
                2'd3:    dat_d = bitcnt_q;
                default: dat_d = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bitcnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            finish_q    <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            prog_rst_q  <= 1'b1;
            prog_we_q   <= 1'b0;
            prog_din_q  <= 1'b0;
            prog_done_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            finish_q    <= finish_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            prog_rst_q  <= prog_rst_d;
            prog_we_q   <= prog_we_d;
            prog_din_q  <= prog_din_d;
            prog_done_q <= prog_done_d;
            irq_q       <= irq_d;
        end
    end

    // Datapath storage carries no reset; pointers and state decide what is valid.
    always_ff @(posedge wb_clk_i) begin
        sr_q       <= sr_d;
        fifo_mem_q <= fifo_mem_d;
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign prog_rst  = prog_rst_q;
    assign prog_we   = prog_we_q;
    assign prog_din  = prog_din_q;
    assign prog_done = prog_done_q;
    assign irq       = irq_q;

endmodule
